wb_write_queue: RTL and testbench

//  Write-side producer for the 32x32 integer register file: collects completed

---
 rtl/riscv_pkg.sv | 18 +
 rtl/wb_fifo.sv | 77 +++++++
 rtl/wb_write_queue.sv | 117 +++++++++++
 tb/tb_wb_write_queue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | riscv_pkg                                                                 |
// | Shared integer-pipeline widths and the write-back queue entry type.       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | wb_fifo                                                                   |
// | Circular buffer, two ordered push ports (port 0 older), one pop port.     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push0,
  input  entry_t                 din0,
  input  logic                   push1,
  input  entry_t                 din1,
  input  logic                   pop,
  output entry_t                 head,
  output entry_t [DEPTH-1:0]     entries,
  output logic   [DEPTH-1:0]     valid,
  output logic   [PW-1:0]        rd_ptr,
  output logic   [CW-1:0]        count
);

  entry_t [DEPTH-1:0] r_mem;
  logic   [DEPTH-1:0] r_valid;
  logic   [PW-1:0]    r_wr_ptr;
  logic   [PW-1:0]    r_rd_ptr;
  logic   [CW-1:0]    r_count;

  logic   [1:0]       w_n_push;
  logic   [PW-1:0]    w_wr_p1;
  logic   [PW-1:0]    w_wr_p2;

  assign w_n_push = {1'b0, push0} + {1'b0, push1};
  assign w_wr_p1  = r_wr_ptr + PW'(1);
  assign w_wr_p2  = r_wr_ptr + PW'(2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '0;
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PW'(1);
      end
      // A lone push on port 1 still lands at the write pointer.
      if (w_n_push != 2'd0) begin
        r_mem[r_wr_ptr]   <= push0 ? din0 : din1;
        r_valid[r_wr_ptr] <= 1'b1;
      end
      if (w_n_push == 2'd2) begin
        r_mem[w_wr_p1]    <= din1;
        r_valid[w_wr_p1]  <= 1'b1;
      end
      r_wr_ptr <= (w_n_push == 2'd2) ? w_wr_p2 :
                  (w_n_push == 2'd1) ? w_wr_p1 : r_wr_ptr;
      r_count  <= r_count + CW'(w_n_push) - CW'(pop);
    end
  end

  assign head    = r_mem[r_rd_ptr];
  assign entries = r_mem;
  assign valid   = r_valid;
  assign rd_ptr  = r_rd_ptr;
  assign count   = r_count;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | wb_write_queue                                                            |
// | Serialises ALU and load results onto the register-file write port and     |
// | forwards queued, unwritten results to the ID stage.                       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module wb_write_queue
  import riscv_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  XLEN  = riscv_pkg::XLEN,
  parameter int  AW    = riscv_pkg::REG_AW,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            fwd1_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd2_data,
  output logic [CW-1:0]   count
);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } entry_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  entry_t               w_head;
  entry_t [DEPTH-1:0]   w_entries;
  logic   [DEPTH-1:0]   w_valid;
  logic   [PW-1:0]      w_rd_ptr;
  logic   [CW-1:0]      w_free;
  logic                 w_push_mem;
  logic                 w_push_alu;
  logic   [AW-1:0]      w_rs_addr  [2];
  logic                 w_fwd_hit  [2];
  logic   [XLEN-1:0]    w_fwd_data [2];

  // Readiness looks only at the registered count; a same-cycle pop frees nothing.
  assign w_free    = DEPTH_C - count;
  assign mem_ready = (w_free != '0);
  assign alu_ready = (w_free >= CW'(2)) || ((w_free == CW'(1)) && !mem_valid);

  assign w_push_mem = mem_valid && mem_ready && (mem_rd != '0);
  assign w_push_alu = alu_valid && alu_ready && (alu_rd != '0);

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push0   (w_push_mem),
    .din0    ('{rd: mem_rd, data: mem_data}),
    .push1   (w_push_alu),
    .din1    ('{rd: alu_rd, data: alu_data}),
    .pop     (rf_we),
    .head    (w_head),
    .entries (w_entries),
    .valid   (w_valid),
    .rd_ptr  (w_rd_ptr),
    .count   (count)
  );

  assign rf_we    = (count != '0);
  assign rf_waddr = rf_we ? w_head.rd   : '0;
  assign rf_wdata = rf_we ? w_head.data : '0;

  assign w_rs_addr[0] = rs1_addr;
  assign w_rs_addr[1] = rs2_addr;

  generate
    for (genvar p = 0; p < 2; p++) begin : g_fwd
      // Walk oldest to youngest so the last match (youngest) wins.
      always_comb begin
        logic [PW-1:0] idx;
        w_fwd_hit[p]  = 1'b0;
        w_fwd_data[p] = '0;
        idx           = '0;
        if (w_rs_addr[p] != '0) begin
          for (int i = 0; i < DEPTH; i++) begin
            idx = w_rd_ptr + PW'(i);
            if (w_valid[idx] && (w_entries[idx].rd == w_rs_addr[p])) begin
              w_fwd_hit[p]  = 1'b1;
              w_fwd_data[p] = w_entries[idx].data;
            end
          end
        end
      end
    end
  endgenerate

  assign fwd1_hit  = w_fwd_hit[0];
  assign fwd1_data = w_fwd_data[0];
  assign fwd2_hit  = w_fwd_hit[1];
  assign fwd2_data = w_fwd_data[1];

endmodule : wb_write_queue
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_wb_write_queue                                                         |
// | Directed and randomized bench for wb_write_queue against a queue model.   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0]  alu_rd = '0, mem_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, rf_we, fwd1_hit, fwd2_hit;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, fwd1_data, fwd2_data;
  logic [2:0]  count;

  wb_write_queue #(.DEPTH(DEPTH), .XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_fwd(input logic [4:0] a);
    if (a == 5'd0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rd == a) return {1'b1, mq[i].data};
    return '0;
  endfunction

  // One clock: drive at negedge, compare against the model, then commit the edge.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic [4:0] r1, input logic [4:0] r2,
                       output logic acc_a, output logic acc_m);
    int          free;
    logic        e_ar, e_mr;
    logic [32:0] f1, f2;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    rs1_addr = r1; rs2_addr = r2;
    #1;
    free = DEPTH - mq.size();
    e_mr = (free >= 1);
    e_ar = (free >= 2) || (free == 1 && !mv);
    f1   = model_fwd(r1);
    f2   = model_fwd(r2);
    check("count",     64'(count),    64'(mq.size()));
    check("rf_we",     64'(rf_we),    64'(mq.size() != 0));
    check("rf_waddr",  64'(rf_waddr), (mq.size() != 0) ? 64'(mq[0].rd)   : 64'd0);
    check("rf_wdata",  64'(rf_wdata), (mq.size() != 0) ? 64'(mq[0].data) : 64'd0);
    check("mem_ready", 64'(mem_ready), 64'(e_mr));
    check("alu_ready", 64'(alu_ready), 64'(e_ar));
    check("fwd1",      {31'd0, fwd1_hit, fwd1_data}, 64'(f1));
    check("fwd2",      {31'd0, fwd2_hit, fwd2_data}, 64'(f2));
    acc_a = av && e_ar;
    acc_m = mv && e_mr;
    @(posedge clk);
    if (mq.size() != 0) void'(mq.pop_front());
    if (acc_m && mrd != 5'd0) mq.push_back('{rd: mrd, data: md});
    if (acc_a && ard != 5'd0) mq.push_back('{rd: ard, data: ad});
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    logic a, m;
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2, a, m);
  endtask

  logic        a_acc, m_acc;
  logic        pa_v, pm_v;
  logic [4:0]  pa_rd, pm_rd;
  logic [31:0] pa_d, pm_d;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);

    // Single ALU write appears one edge later, then queue empties.
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, a_acc, m_acc);
    #1;
    check("t1_we",    64'(rf_we),    64'd1);
    check("t1_waddr", 64'(rf_waddr), 64'd5);
    check("t1_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Dual push to x3: mem first, youngest (alu) forwarded.
    cycle(1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 32'h11, 5'd0, 5'd0, a_acc, m_acc);
    #1;
    check("t2_fwd1", {31'd0, fwd1_hit, fwd1_data}, 64'd0);
    idle(5'd3, 5'd3);
    idle(5'd3, 5'd0);
    idle(5'd0, 5'd0);

    // Fill: dual pushes until free==1, then mem wins the last slot.
    cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 5'd1, 5'd2, a_acc, m_acc);
    cycle(1'b1, 5'd1, 32'hA3, 1'b1, 5'd2, 32'hB4, 5'd1, 5'd2, a_acc, m_acc);
    cycle(1'b1, 5'd4, 32'hA5, 1'b1, 5'd6, 32'hB6, 5'd4, 5'd6, a_acc, m_acc);
    check("t3_alu_blocked", 64'(a_acc), 64'd0);
    repeat (4) idle(5'd6, 5'd1);

    // rd==0 accepted but dropped.
    cycle(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, a_acc, m_acc);
    check("t4_acc", 64'(a_acc), 64'd1);
    idle(5'd0, 5'd0);

    // Forward miss, then one x7 entry hitting on both ports.
    idle(5'd0, 5'd7);
    cycle(1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, a_acc, m_acc);
    idle(5'd7, 5'd7);

    // Async reset with three entries queued.
    cycle(1'b1, 5'd8, 32'hC1, 1'b1, 5'd9, 32'hC2, 5'd0, 5'd0, a_acc, m_acc);
    cycle(1'b1, 5'd10, 32'hC3, 1'b1, 5'd11, 32'hC4, 5'd0, 5'd0, a_acc, m_acc);
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    check("t6_pre_count", 64'(count), 64'd3);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_we",    64'(rf_we), 64'd0);
    mq.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(5'd10, 5'd11);
    idle(5'd0, 5'd0);

    // Randomized traffic; producers hold offers until accepted.
    pa_v = 1'b0; pm_v = 1'b0;
    pa_rd = '0; pm_rd = '0; pa_d = '0; pm_d = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pa_v && $urandom_range(0, 1) == 1) begin
        pa_v = 1'b1; pa_rd = 5'($urandom_range(0, 7)); pa_d = $urandom;
      end
      if (!pm_v && $urandom_range(0, 2) == 0) begin
        pm_v = 1'b1; pm_rd = 5'($urandom_range(0, 7)); pm_d = $urandom;
      end
      cycle(pa_v, pa_rd, pa_d, pm_v, pm_rd, pm_d,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), a_acc, m_acc);
      if (a_acc) pa_v = 1'b0;
      if (m_acc) pm_v = 1'b0;
    end
    repeat (5) idle(5'd0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wb_write_queue
`default_nettype wire
